// File: rtl/temp_collect_if.sv
// rtl/temp_collect_if.sv - sample input, frame output and status bundle for temp_collect
interface temp_collect_if #(
    parameter int W = 16
);
    logic         sample_valid;
    logic [W-1:0] sample_data;
    logic         sample_ready;
    logic [W-1:0] temp1;
    logic [W-1:0] temp2;
    logic [W-1:0] temp3;
    logic [W-1:0] temp4;
    logic         frame_valid;
    logic         frame_ack;
    logic [7:0]   frame_count;
    logic         timeout_flag;

    modport master (
        output sample_valid, sample_data, frame_ack,
        input  sample_ready, temp1, temp2, temp3, temp4,
               frame_valid, frame_count, timeout_flag
    );

    modport slave (
        input  sample_valid, sample_data, frame_ack,
        output sample_ready, temp1, temp2, temp3, temp4,
               frame_valid, frame_count, timeout_flag
    );
endinterface

// File: rtl/temp_collect.sv
// rtl/temp_collect.sv - gathers four temperature samples into a held frame
// Optional partial-frame timeout is compiled in with TEMP_COLLECT_TIMEOUT_EN.
module temp_collect #(
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    temp_collect_if.slave bus
);
    typedef enum logic {FILL, HOLD} state_t;

    state_t       state;
    state_t       state_next;
    logic [1:0]   idx;
    logic [W-1:0] t1;
    logic [W-1:0] t2;
    logic [W-1:0] t3;
    logic [W-1:0] t4;
    logic         fv;
    logic [7:0]   fcnt;
    logic         accept;
    logic         frame_done;
    logic         ack_take;
    logic         idle_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        frame_done = 1'b0;
        ack_take   = 1'b0;
        case (state)
            FILL: begin
                accept = bus.sample_valid;
                if (accept && idx == 2'd3) begin
                    frame_done = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // The ack edge only releases the frame; a waiting sample is taken next edge.
                if (bus.frame_ack) begin
                    ack_take   = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= 2'd0;
            t1   <= '0;
            t2   <= '0;
            t3   <= '0;
            t4   <= '0;
            fv   <= 1'b0;
            fcnt <= 8'd0;
        end else begin
            if (accept) begin
                case (idx)
                    2'd0:    t1 <= bus.sample_data;
                    2'd1:    t2 <= bus.sample_data;
                    2'd2:    t3 <= bus.sample_data;
                    default: t4 <= bus.sample_data;
                endcase
                idx <= idx + 2'd1;
            end else if (idle_fire) begin
                idx <= 2'd0;
            end
            if (frame_done) begin
                fv   <= 1'b1;
                fcnt <= fcnt + 8'd1;
            end else if (ack_take) begin
                fv <= 1'b0;
            end
        end
    end

`ifdef TEMP_COLLECT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt;
    logic          to_flag;

    // An acceptance on the would-be timeout edge wins, so accept gates the fire.
    assign idle_fire = (state == FILL) && (idx != 2'd0) && !accept
                       && (idle_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            to_flag  <= 1'b0;
        end else begin
            to_flag <= idle_fire;
            if (state != FILL || idx == 2'd0 || accept || idle_fire)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + CW'(1);
        end
    end

    assign bus.timeout_flag = to_flag;
`else
    logic unused_timeout;
    assign unused_timeout   = (TIMEOUT > 0);
    assign idle_fire        = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    assign bus.sample_ready = (state == FILL);
    assign bus.temp1        = t1;
    assign bus.temp2        = t2;
    assign bus.temp3        = t3;
    assign bus.temp4        = t4;
    assign bus.frame_valid  = fv;
    assign bus.frame_count  = fcnt;
endmodule

// File: tb/tb_temp_collect.sv
// tb/tb_temp_collect.sv - self-checking bench for temp_collect
module tb_temp_collect;
    localparam int W  = 16;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;

    temp_collect_if #(.W(W)) bus ();

    temp_collect #(.W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         a;
        logic         exp_fv;
        logic         exp_rdy;
    } vec_t;

    typedef struct {
        logic [W-1:0] t1;
        logic [W-1:0] t2;
        logic [W-1:0] t3;
        logic [W-1:0] t4;
        logic [7:0]   cnt;
    } frame_t;

    vec_t   tbl[$];
    frame_t sb[$];
    frame_t held;
    int     checks = 0;
    int     errors = 0;

    logic         m_hold;
    logic [1:0]   m_idx;
    logic [W-1:0] m_slot [4];
    logic [7:0]   m_cnt;
    logic         prev_fv;
    logic         exp_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hold  = 1'b0;
        m_idx   = 2'd0;
        m_cnt   = 8'd0;
        prev_fv = 1'b0;
        exp_to  = 1'b0;
        sb.delete();
    endtask

    task automatic add_vec(input logic v, input logic [W-1:0] d, input logic a,
                           input logic fv, input logic rdy);
        vec_t t;
        t.v = v; t.d = d; t.a = a; t.exp_fv = fv; t.exp_rdy = rdy;
        tbl.push_back(t);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic a);
        frame_t f;
        bus.sample_valid = v;
        bus.sample_data  = d;
        bus.frame_ack    = a;
        if (!m_hold && v) begin
            m_slot[m_idx] = d;
            if (m_idx == 2'd3) begin
                m_cnt  = m_cnt + 8'd1;
                m_hold = 1'b1;
                f.t1 = m_slot[0]; f.t2 = m_slot[1]; f.t3 = m_slot[2]; f.t4 = m_slot[3];
                f.cnt = m_cnt;
                sb.push_back(f);
            end
            m_idx = m_idx + 2'd1;
        end else if (m_hold && a) begin
            m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
        check("frame_valid", bus.frame_valid, m_hold);
        check("sample_ready", bus.sample_ready, !m_hold);
        check("frame_count", bus.frame_count, m_cnt);
        check("timeout_flag", bus.timeout_flag, exp_to);
        if (bus.frame_valid && !prev_fv) begin
            if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
            else held = sb.pop_front();
        end
        if (bus.frame_valid) begin
            check("frame_temp1", bus.temp1, held.t1);
            check("frame_temp2", bus.temp2, held.t2);
            check("frame_temp3", bus.temp3, held.t3);
            check("frame_temp4", bus.temp4, held.t4);
            check("frame_cnt_sb", bus.frame_count, held.cnt);
        end
        prev_fv = bus.frame_valid;
    endtask

    task automatic do_reset();
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.frame_ack    = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        do_reset();
        rst = 1'b1;
        #1;
        check("rst_temp1", bus.temp1, 0);
        check("rst_temp4", bus.temp4, 0);
        check("rst_fv", bus.frame_valid, 0);
        check("rst_cnt", bus.frame_count, 0);
        check("rst_rdy", bus.sample_ready, 1);
        check("rst_to", bus.timeout_flag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame 2,2,4,4; held under sample_valid; ack edge takes nothing; 9 lands next edge.
        add_vec(1, 2, 0, 0, 1);
        add_vec(1, 2, 0, 0, 1);
        add_vec(1, 4, 0, 0, 1);
        add_vec(1, 4, 0, 1, 0);
        for (int i = 0; i < 5; i++) add_vec(1, 9, 0, 1, 0);
        add_vec(1, 9, 1, 0, 1);
        add_vec(1, 9, 0, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].a);
            check($sformatf("vec%0d_fv", i), bus.frame_valid, tbl[i].exp_fv);
            check($sformatf("vec%0d_rdy", i), bus.sample_ready, tbl[i].exp_rdy);
            if (i == 3) begin
                check("v4_t1", bus.temp1, 2);
                check("v4_t3", bus.temp3, 4);
                check("v4_cnt", bus.frame_count, 1);
            end
        end
        check("ack_skip_t1", bus.temp1, 9);
        check("retain_t2", bus.temp2, 2);
        step(0, 0, 1);
        check("fill_ack_ignored", bus.sample_ready, 1);
        step(1, 11, 0);
        step(1, 12, 0);
        step(1, 13, 0);
        step(0, 0, 1);

        // Frame counter wrap after 256 delivered frames.
        do_reset();
        for (int f = 0; f < 256; f++) begin
            for (int s = 0; s < 4; s++) step(1, W'($urandom), 0);
            step(0, 0, 1);
        end
        check("cnt_wrap", bus.frame_count, 0);

        // Reset mid-frame discards the partial frame.
        do_reset();
        step(1, 16'h77, 0);
        step(1, 16'h88, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_t1", bus.temp1, 0);
        check("midrst_t2", bus.temp2, 0);
        check("midrst_fv", bus.frame_valid, 0);
        check("midrst_cnt", bus.frame_count, 0);
        check("midrst_rdy", bus.sample_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1, 5, 0);
        step(1, 6, 0);
        step(1, 7, 0);
        step(1, 8, 0);
        check("midrst_frame_t1", bus.temp1, 5);
        check("midrst_frame_t4", bus.temp4, 8);
        step(0, 0, 1);

`ifdef TEMP_COLLECT_TIMEOUT_EN
        do_reset();
        step(1, 3, 0);
        for (int i = 0; i < TO - 1; i++) step(0, 0, 0);
        exp_to = 1'b1;
        step(0, 0, 0);
        m_idx  = 2'd0;
        exp_to = 1'b0;
        check("to_cnt", bus.frame_count, 0);
        step(1, 10, 0);
        check("to_reload_t1", bus.temp1, 10);
        step(1, 20, 0);
        step(1, 30, 0);
        step(1, 40, 0);
        step(0, 0, 1);
`else
        do_reset();
        step(1, 21, 0);
        step(1, 22, 0);
        step(1, 23, 0);
        for (int i = 0; i < 1000; i++) step(0, 0, 0);
        step(1, 24, 0);
        check("noto_fv", bus.frame_valid, 1);
        check("noto_t1", bus.temp1, 21);
        check("noto_t4", bus.temp4, 24);
        step(0, 0, 1);
`endif

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
